// File: rtl/ychip_int_ctrl.sv
// yChip upstream control stage: boot redirect, interrupt entry and return redirect.
// Optional ICTRL_IRQ_LEVEL_EN selects level-sensitive irq sampling instead of rising-edge latching.
module ychip_int_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'd128,
  parameter int          NUM_IRQ      = 4,
  parameter logic [31:0] VEC_BASE     = 32'd512,
  parameter logic [31:0] VEC_STRIDE   = 32'd16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               ie,
  input  logic               ret,
  input  logic [31:0]        pc_in,
  output logic               INT,
  output logic [31:0]        entryPoint,
  output logic [2:0]         cause,
  output logic [31:0]        epc,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_isr
);

  localparam logic [2:0] ST_BOOT   = 3'd0;
  localparam logic [2:0] ST_RUN    = 3'd1;
  localparam logic [2:0] ST_TAKE   = 3'd2;
  localparam logic [2:0] ST_ISR    = 3'd3;
  localparam logic [2:0] ST_RESUME = 3'd4;

  logic [2:0]         state_reg;
  logic               int_reg;
  logic [31:0]        entry_reg;
  logic [2:0]         cause_reg;
  logic [31:0]        epc_reg;
  logic [NUM_IRQ-1:0] pending_reg;
  logic [NUM_IRQ-1:0] pending_next;
  logic               in_isr_reg;
  logic [2:0]         idx;
  logic [31:0]        vec_addr;
  logic               take;

  // Fixed priority: scanning downward leaves the lowest set bit in idx.
  always_comb begin
    idx = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending_reg[i]) idx = 3'(i);
    end
  end

  assign vec_addr = VEC_BASE + ({29'd0, idx} * VEC_STRIDE);
  assign take     = (state_reg == ST_RUN) && ie && (|pending_reg);

`ifdef ICTRL_IRQ_LEVEL_EN
  // Level mode: pending simply mirrors the request lines, the handler must drop them.
  assign pending_next = irq;
`else
  logic [NUM_IRQ-1:0] irq_q_reg;
  logic [NUM_IRQ-1:0] take_mask;

  generate
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_pend
      assign take_mask[gi] = take && (idx == 3'(gi));
      // A new rising edge wins over a clear in the same cycle.
      assign pending_next[gi] = (irq[gi] & ~irq_q_reg[gi]) | (pending_reg[gi] & ~take_mask[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q_reg <= '0;
    else     irq_q_reg <= irq;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_BOOT;
      int_reg     <= 1'b1;
      entry_reg   <= RESET_VECTOR;
      cause_reg   <= 3'd0;
      epc_reg     <= 32'd0;
      pending_reg <= '0;
      in_isr_reg  <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      case (state_reg)
        ST_BOOT: begin
          state_reg <= ST_RUN;
          int_reg   <= 1'b0;
        end
        ST_RUN: begin
          if (take) begin
            state_reg  <= ST_TAKE;
            int_reg    <= 1'b1;
            entry_reg  <= vec_addr;
            cause_reg  <= idx;
            epc_reg    <= pc_in;
            in_isr_reg <= 1'b1;
          end
        end
        ST_TAKE: begin
          state_reg <= ST_ISR;
          int_reg   <= 1'b0;
        end
        ST_ISR: begin
          if (ret) begin
            state_reg <= ST_RESUME;
            int_reg   <= 1'b1;
            entry_reg <= epc_reg;
          end
        end
        ST_RESUME: begin
          state_reg  <= ST_RUN;
          int_reg    <= 1'b0;
          in_isr_reg <= 1'b0;
        end
        default: begin
          state_reg <= ST_BOOT;
          int_reg   <= 1'b1;
          entry_reg <= RESET_VECTOR;
        end
      endcase
    end
  end

  assign INT        = int_reg;
  assign entryPoint = entry_reg;
  assign cause      = cause_reg;
  assign epc        = epc_reg;
  assign pending    = pending_reg;
  assign in_isr     = in_isr_reg;

endmodule

// File: tb/tb_ychip_int_ctrl.sv
// Directed bench for ychip_int_ctrl: boot, entry, priority, masking, no nesting, reset in ISR.
module tb_ychip_int_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  irq = 4'd0;
  logic        ie = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        INT;
  logic [31:0] entryPoint;
  logic [2:0]  cause;
  logic [31:0] epc;
  logic [3:0]  pending;
  logic        in_isr;

  int tests_run = 0;
  int tests_failed = 0;

  ychip_int_ctrl dut (
    .clk(clk), .rst(rst), .irq(irq), .ie(ie), .ret(ret), .pc_in(pc_in),
    .INT(INT), .entryPoint(entryPoint), .cause(cause), .epc(epc),
    .pending(pending), .in_isr(in_isr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Boot: asynchronous assert before any clock edge
    #2 rst = 1'b1;
    #1;
    check("rst_int", {31'd0, INT}, 32'd1);
    check("rst_entry", entryPoint, 32'd128);
    check("rst_cause", {29'd0, cause}, 32'd0);
    check("rst_epc", epc, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_in_isr", {31'd0, in_isr}, 32'd0);
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("boot_int_hold", {31'd0, INT}, 32'd1);
    check("boot_entry_hold", entryPoint, 32'd128);
    tick();
    check("boot_int_drop", {31'd0, INT}, 32'd0);
    check("boot_entry_keep", entryPoint, 32'd128);

    // Single irq[2]
    ie = 1'b1; pc_in = 32'h9C; irq = 4'b0100;
    tick();
    check("s_pend_set", {28'd0, pending}, 32'h4);
    check("s_int_wait", {31'd0, INT}, 32'd0);
    irq = 4'b0000;
    tick();
    check("s_int", {31'd0, INT}, 32'd1);
    check("s_entry", entryPoint, 32'd544);
    check("s_cause", {29'd0, cause}, 32'd2);
    check("s_epc", epc, 32'h9C);
    check("s_in_isr", {31'd0, in_isr}, 32'd1);
    check("s_pend_clr", {28'd0, pending}, 32'd0);
    tick();
    check("s_int_one_cycle", {31'd0, INT}, 32'd0);
    check("s_entry_keep", entryPoint, 32'd544);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("s_resume_int", {31'd0, INT}, 32'd1);
    check("s_resume_entry", entryPoint, 32'h9C);
    tick();
    check("s_run_int", {31'd0, INT}, 32'd0);
    check("s_run_in_isr", {31'd0, in_isr}, 32'd0);

    // Priority: irq[3] and irq[1] together
    pc_in = 32'h200; irq = 4'b1010;
    tick();
    check("p_pend", {28'd0, pending}, 32'hA);
    irq = 4'b0000;
    tick();
    check("p1_int", {31'd0, INT}, 32'd1);
    check("p1_entry", entryPoint, 32'd528);
    check("p1_cause", {29'd0, cause}, 32'd1);
    check("p1_pend", {28'd0, pending}, 32'h8);
    tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("p1_resume_entry", entryPoint, 32'h200);
    check("p1_resume_int", {31'd0, INT}, 32'd1);
    pc_in = 32'h280;
    tick();
    check("p_back_run_int", {31'd0, INT}, 32'd0);
    tick();
    check("p2_int", {31'd0, INT}, 32'd1);
    check("p2_entry", entryPoint, 32'd560);
    check("p2_cause", {29'd0, cause}, 32'd3);
    check("p2_epc", epc, 32'h280);
    tick();
    ret = 1'b1;
    tick();
    ret = 1'b0;
    tick();

    // ret in RUN is ignored
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("ret_run_ignored", {31'd0, INT}, 32'd0);

    // Masking
    ie = 1'b0; pc_in = 32'h300; irq = 4'b0001;
    tick();
    irq = 4'b0000;
    tick();
    check("m_pend", {28'd0, pending}, 32'h1);
    check("m_int_masked", {31'd0, INT}, 32'd0);
    tick();
    check("m_int_masked2", {31'd0, INT}, 32'd0);
    ie = 1'b1;
    tick();
    check("m_int", {31'd0, INT}, 32'd1);
    check("m_entry", entryPoint, 32'd512);
    check("m_cause", {29'd0, cause}, 32'd0);
    tick();

    // No nesting inside the handler
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    check("n_pend", {28'd0, pending}, 32'h1);
    check("n_no_int", {31'd0, INT}, 32'd0);
    tick();
    check("n_no_int2", {31'd0, INT}, 32'd0);
    ret = 1'b1;
    tick();
    ret = 1'b0;
    check("n_resume_int", {31'd0, INT}, 32'd1);
    check("n_resume_entry", entryPoint, 32'h300);
    pc_in = 32'h404;
    tick();
    check("n_run_int", {31'd0, INT}, 32'd0);
    check("n_run_pend", {28'd0, pending}, 32'h1);
    tick();
    check("n_take_int", {31'd0, INT}, 32'd1);
    check("n_take_entry", entryPoint, 32'd512);
    check("n_take_epc", epc, 32'h404);
    tick();

    // Reset while in the handler, with a pending request outstanding
    irq = 4'b0010;
    tick();
    irq = 4'b0000;
    check("r_pre_pend", {28'd0, pending}, 32'h2);
    check("r_pre_in_isr", {31'd0, in_isr}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("r_int", {31'd0, INT}, 32'd1);
    check("r_entry", entryPoint, 32'd128);
    check("r_in_isr", {31'd0, in_isr}, 32'd0);
    check("r_pend", {28'd0, pending}, 32'd0);
    check("r_epc", epc, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("r_boot_exit", {31'd0, INT}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
